// File: rtl/svm_norm_pkg.sv
// Shared types and widths for the fixed-point normaliser and its downstream consumers.
package svm_norm_pkg;

    localparam int unsigned NORM_W = 16;
    localparam int unsigned EXP_W  = $clog2(NORM_W);

    typedef struct packed {
        logic [NORM_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              sign;
        logic              zero;
    } norm_res_t;

endpackage

// File: rtl/detect_pos_first_one.sv
// Leading-zero count of a word: distance of the leading one from the MSB, 0 for a zero word.
module detect_pos_first_one #(
    parameter int unsigned D_WIDTH = 16
) (
    input  logic [D_WIDTH-1:0]         data_i,
    output logic [$clog2(D_WIDTH)-1:0] pos_o
);

    localparam int unsigned POS_W = $clog2(D_WIDTH);

    // Scan upward so the highest set bit wins.
    always_comb begin
        pos_o = '0;
        for (int i = 0; i < int'(D_WIDTH); i++) begin
            if (data_i[i]) begin
                pos_o = POS_W'(int'(D_WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lz_normalizer.sv
// Two-stage valid/ready normaliser: left-justifies a fixed-point word and reports exponent, sign and zero.
module lz_normalizer
    import svm_norm_pkg::*;
#(
    parameter int unsigned D_WIDTH = NORM_W,
    parameter bit          SIGNED  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [D_WIDTH-1:0]         data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [D_WIDTH-1:0]         mant_o,
    output logic [$clog2(D_WIDTH)-1:0] exp_o,
    output logic                       sign_o,
    output logic                       zero_o
);

    localparam int unsigned E_W = $clog2(D_WIDTH);

    // Same layout as norm_res_t, sized by this instance's width.
    typedef struct packed {
        logic [D_WIDTH-1:0] mant;
        logic [E_W-1:0]     exp;
        logic               sign;
        logic               zero;
    } res_t;

    logic               adv2;
    logic               accept;
    logic               neg;
    logic [D_WIDTH-1:0] mag;
    logic [E_W-1:0]     lz;

    logic               s1_valid;
    logic [D_WIDTH-1:0] s1_mag;
    logic [E_W-1:0]     s1_lz;
    logic               s1_sign;
    logic               s1_zero;

    res_t               s2;
    res_t               s2_next;

    assign adv2    = !valid_o || ready_i;
    assign ready_o = !rst && (!s1_valid || adv2);
    assign accept  = valid_i && ready_o;

    // Most-negative input negates to 2^(D_WIDTH-1), which is exact as unsigned.
    assign neg = SIGNED && data_i[D_WIDTH-1];
    assign mag = neg ? D_WIDTH'(~data_i + 1'b1) : data_i;

    detect_pos_first_one #(
        .D_WIDTH (D_WIDTH)
    ) u_lod (
        .data_i (mag),
        .pos_o  (lz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_lz    <= '0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_mag   <= mag;
            s1_lz    <= lz;
            s1_sign  <= neg;
            s1_zero  <= (mag == '0);
        end else if (s1_valid && adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // The detector reports 0 for a zero word, so zero must force every field.
    always_comb begin
        s2_next      = '0;
        s2_next.zero = s1_zero;
        if (!s1_zero) begin
            s2_next.mant = s1_mag << s1_lz;
            s2_next.exp  = E_W'(D_WIDTH - 1) - s1_lz;
            s2_next.sign = s1_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2      <= '0;
            valid_o <= 1'b0;
        end else if (s1_valid && adv2) begin
            s2      <= s2_next;
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    assign mant_o = s2.mant;
    assign exp_o  = s2.exp;
    assign sign_o = s2.sign;
    assign zero_o = s2.zero;

endmodule

// File: tb/tb_lz_normalizer.sv
// Bench for lz_normalizer: unsigned and signed instances share stimulus; table vectors plus a scoreboard.
module tb_lz_normalizer;

    localparam int unsigned W  = 16;
    localparam int unsigned EW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  data_i;
    logic          valid_i;
    logic          ready_i;

    logic          u_ready, u_valid, u_sign, u_zero;
    logic [W-1:0]  u_mant;
    logic [EW-1:0] u_exp;
    logic          s_ready, s_valid, s_sign, s_zero;
    logic [W-1:0]  s_mant;
    logic [EW-1:0] s_exp;

    int checks = 0;
    int errors = 0;

    lz_normalizer #(.D_WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(u_ready),
        .valid_o(u_valid), .ready_i(ready_i), .mant_o(u_mant), .exp_o(u_exp),
        .sign_o(u_sign), .zero_o(u_zero)
    );

    lz_normalizer #(.D_WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(s_ready),
        .valid_o(s_valid), .ready_i(ready_i), .mant_o(s_mant), .exp_o(s_exp),
        .sign_o(s_sign), .zero_o(s_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic          zero;
    } res_t;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [W-1:0]  u_mant;
        logic [EW-1:0] u_exp;
        logic [W-1:0]  s_mant;
        logic [EW-1:0] s_exp;
        logic          s_sign;
        logic          zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: shift left one bit at a time until the MSB is set.
    function automatic res_t ref_norm(input logic [W-1:0] d, input bit sgn);
        res_t         r;
        logic [W-1:0] m;
        int           e;
        r.sign = sgn && d[W-1];
        m      = r.sign ? W'(0 - d) : d;
        r.zero = (m == '0);
        r.mant = '0;
        r.exp  = '0;
        if (r.zero) begin
            r.sign = 1'b0;
        end else begin
            e = W - 1;
            while (!m[W-1]) begin
                m = m << 1;
                e--;
            end
            r.mant = m;
            r.exp  = EW'(e);
        end
        return r;
    endfunction

    res_t uq[$];
    res_t sq[$];

    // Scoreboard sampled mid-cycle: handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            uq.delete();
            sq.delete();
        end else begin
            check("ready_match", {31'd0, s_ready}, {31'd0, u_ready});
            if (u_valid && ready_i) begin
                if (uq.size() == 0 || sq.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    check("sb_unsigned", 32'({u_mant, u_exp, u_sign, u_zero}), 32'(uq.pop_front()));
                    check("sb_signed",   32'({s_mant, s_exp, s_sign, s_zero}), 32'(sq.pop_front()));
                    check("sb_valid_s",  {31'd0, s_valid}, 32'd1);
                end
            end
            if (valid_i && u_ready) begin
                uq.push_back(ref_norm(data_i, 1'b0));
                sq.push_back(ref_norm(data_i, 1'b1));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [9];
        int   n;

        vecs[0] = '{16'h0001, 16'h8000, 4'd0,  16'h8000, 4'd0,  1'b0, 1'b0};
        vecs[1] = '{16'h8000, 16'h8000, 4'd15, 16'h8000, 4'd15, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 4'd0,  16'h0000, 4'd0,  1'b0, 1'b1};
        vecs[3] = '{16'h0003, 16'hC000, 4'd1,  16'hC000, 4'd1,  1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 4'd15, 16'h8000, 4'd0,  1'b1, 1'b0};
        vecs[5] = '{16'h00F0, 16'hF000, 4'd7,  16'hF000, 4'd7,  1'b0, 1'b0};
        vecs[6] = '{16'hFFFE, 16'hFFFE, 4'd15, 16'h8000, 4'd1,  1'b1, 1'b0};
        vecs[7] = '{16'h7FFF, 16'hFFFE, 4'd14, 16'hFFFE, 4'd14, 1'b0, 1'b0};
        vecs[8] = '{16'hC000, 16'hC000, 4'd15, 16'h8000, 4'd14, 1'b1, 1'b0};

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
        tick; tick;
        check("rst_valid", {31'd0, u_valid}, 32'd0);
        check("rst_outs",  32'({u_mant, u_exp, u_sign, u_zero}), 32'd0);
        check("rst_ready", {31'd0, u_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, u_ready}, 32'd1);

        // Back-to-back pair: latency 2, then one result per cycle.
        data_i = 16'h0001; valid_i = 1'b1;
        tick;
        check("lat_valid_early", {31'd0, u_valid}, 32'd0);
        data_i = 16'h8000;
        tick;
        valid_i = 1'b0;
        check("lat_valid", {31'd0, u_valid}, 32'd1);
        check("lat_w1", 32'({u_mant, u_exp, u_zero}), 32'({16'h8000, 4'd0, 1'b0}));
        tick;
        check("lat_w2", 32'({u_valid, u_mant, u_exp}), 32'({1'b1, 16'h8000, 4'd15}));
        tick;
        check("lat_drain", {31'd0, u_valid}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            data_i = vecs[i].data; valid_i = 1'b1;
            tick;
            valid_i = 1'b0;
            n = 0;
            while (!u_valid && n < 5) begin
                tick;
                n++;
            end
            check("vec_valid", {31'd0, u_valid}, 32'd1);
            check("vec_u", 32'({u_mant, u_exp, u_sign, u_zero}),
                  32'({vecs[i].u_mant, vecs[i].u_exp, 1'b0, vecs[i].zero}));
            check("vec_s", 32'({s_mant, s_exp, s_sign, s_zero}),
                  32'({vecs[i].s_mant, vecs[i].s_exp, vecs[i].s_sign, vecs[i].zero}));
            tick;
        end

        // Backpressure: two words held, third stalls until ready_i rises.
        ready_i = 1'b0;
        data_i = 16'h0003; valid_i = 1'b1;
        tick;
        data_i = 16'h0030;
        tick;
        data_i = 16'h0300;
        #1;
        check("bp_ready_low", {31'd0, u_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_ready_hold", {31'd0, u_ready}, 32'd0);
            check("bp_stable", 32'({u_valid, u_mant, u_exp}), 32'({1'b1, 16'hC000, 4'd1}));
        end
        ready_i = 1'b1;
        #1;
        check("bp_ready_back", {31'd0, u_ready}, 32'd1);
        tick;
        valid_i = 1'b0;
        check("bp_second", 32'({u_valid, u_mant, u_exp}), 32'({1'b1, 16'hC000, 4'd5}));
        tick;
        check("bp_third", 32'({u_valid, u_mant, u_exp}), 32'({1'b1, 16'hC000, 4'd9}));
        tick;
        check("bp_drain", {31'd0, u_valid}, 32'd0);

        // Full throughput with random words.
        for (int i = 0; i < 32; i++) begin
            data_i = (i == 4) ? 16'h0000 : (i == 9) ? 16'h8000 : W'($urandom);
            valid_i = 1'b1;
            #1;
            check("tp_ready", {31'd0, u_ready}, 32'd1);
            tick;
            if (i >= 1) check("tp_valid", {31'd0, u_valid}, 32'd1);
        end
        valid_i = 1'b0;
        tick;
        check("tp_valid_tail", {31'd0, u_valid}, 32'd1);
        tick; tick;
        check("tp_drain", {31'd0, u_valid}, 32'd0);

        // Reset with both stages full: nothing in flight survives.
        ready_i = 1'b0;
        data_i = 16'h0005; valid_i = 1'b1;
        tick;
        data_i = 16'h0050;
        tick;
        valid_i = 1'b0;
        check("mr_full", {31'd0, u_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mr_ready_low", {31'd0, u_ready}, 32'd0);
        tick;
        check("mr_valid", {30'd0, u_valid, s_valid}, 32'd0);
        check("mr_outs", 32'({u_mant, u_exp, u_sign, u_zero}), 32'd0);
        rst = 1'b0; ready_i = 1'b1;
        #1;
        check("mr_ready_after", {31'd0, u_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("mr_no_stale", {30'd0, u_valid, s_valid}, 32'd0);
        end

        check("sb_empty", 32'(uq.size() + sq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
